// File: rtl/switch_stage_pkg.sv
// Shared constants, state encoding and control-table lookup for the dp4
// 2x2 switch stage.
package switch_stage_pkg;

    localparam int DP    = 4;
    localparam int CNT_W = 2;

    // Bit k is the cross control for beat k.
    localparam logic [DP-1:0] SW0_CTRL = 4'b1010;
    localparam logic [DP-1:0] SW1_CTRL = 4'b1100;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Returns {sw1_cross, sw0_cross} for beat k.
    function automatic logic [1:0] ctrl_lookup(input logic [CNT_W-1:0] k);
        return {SW1_CTRL[k], SW0_CTRL[k]};
    endfunction

endpackage

// File: rtl/switch_ctrl_dp4.sv
// Beat counter and FSM for the dp4 switch stage; turns the beat index into
// per-switch cross controls and regenerates the block start pulse.
module switch_ctrl_dp4
    import switch_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_start,
    output logic sw_ctrl_0,
    output logic sw_ctrl_1,
    output logic busy,
    output logic start_d
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q;
    logic [CNT_W-1:0]   beat_k;
    logic               in_block;
    logic [1:0]         ctrl;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_k   = cnt_q;
        in_block = (state_q == RUN);
        // A start pulse always wins, even mid-block: this cycle becomes beat 0.
        if (in_start) begin
            beat_k   = '0;
            in_block = 1'b1;
            state_d  = RUN;
            cnt_d    = CNT_W'(1);
        end else if (state_q == RUN) begin
            if (cnt_q == CNT_W'(3)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign ctrl      = in_block ? ctrl_lookup(beat_k) : 2'b00;
    assign sw_ctrl_0 = ctrl[0];
    assign sw_ctrl_1 = ctrl[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= in_start;
        end
    end

    assign busy    = (state_q == RUN);
    assign start_d = start_q;

endmodule

// File: rtl/switch_stage_dp4.sv
// Four-lane stage with two 2x2 switches (lanes 0/1 and 2/3) driven by a
// per-beat control table; one cycle of registered latency on data and start.
module switch_stage_dp4
    import switch_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic [DATA_WIDTH-1:0] in_data_0,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic [DATA_WIDTH-1:0] in_data_3,
    output logic [DATA_WIDTH-1:0] out_data_0,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic [DATA_WIDTH-1:0] out_data_3,
    output logic                  out_start,
    output logic                  busy
);

    // The 2-bit beat counter only covers a 4-beat block.
    if (BLOCK_LEN != (1 << CNT_W)) begin : g_bad_block_len
        $error("switch_stage_dp4 supports BLOCK_LEN == 4 only");
    end

    logic [DP-1:0][DATA_WIDTH-1:0] lane_in;
    logic [DP-1:0][DATA_WIDTH-1:0] lane_sw;
    logic [DP-1:0][DATA_WIDTH-1:0] lane_q;
    logic [DP/2-1:0]               sw_ctrl;
    logic                          start_d;

    assign lane_in[0] = in_data_0;
    assign lane_in[1] = in_data_1;
    assign lane_in[2] = in_data_2;
    assign lane_in[3] = in_data_3;

    switch_ctrl_dp4 u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_start),
        .sw_ctrl_0 (sw_ctrl[0]),
        .sw_ctrl_1 (sw_ctrl[1]),
        .busy      (busy),
        .start_d   (start_d)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DP/2; gi++) begin : g_switch
            assign lane_sw[2*gi]   = sw_ctrl[gi] ? lane_in[2*gi+1] : lane_in[2*gi];
            assign lane_sw[2*gi+1] = sw_ctrl[gi] ? lane_in[2*gi]   : lane_in[2*gi+1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_sw;
        end
    end

    assign out_data_0 = lane_q[0];
    assign out_data_1 = lane_q[1];
    assign out_data_2 = lane_q[2];
    assign out_data_3 = lane_q[3];
    assign out_start  = start_d;

endmodule

// File: tb/tb_switch_stage_dp4.sv
// Directed plus randomized bench for switch_stage_dp4 against a beat-index model.
module tb_switch_stage_dp4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_start;
    logic [7:0] in_data_0, in_data_1, in_data_2, in_data_3;
    logic [7:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic       out_start;
    logic       busy;

    int vectors = 0;
    int misses  = 0;

    always #5 clk = ~clk;

    switch_stage_dp4 #(.DATA_WIDTH(8), .BLOCK_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_start   (in_start),
        .in_data_0  (in_data_0),
        .in_data_1  (in_data_1),
        .in_data_2  (in_data_2),
        .in_data_3  (in_data_3),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_data_3 (out_data_3),
        .out_start  (out_start),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: track which beat of a block each input cycle is (-1 = outside a block).
    int         m_beat  = -1;
    bit         m_ready = 1'b0;
    logic [7:0] e_d0, e_d1, e_d2, e_d3;
    logic       e_start, e_busy;

    always @(posedge clk) begin
        int  k;
        bit  x0, x1;
        if (!rst) begin
            m_beat = -1;
            {e_d0, e_d1, e_d2, e_d3} = '0;
            e_start = 1'b0;
            e_busy  = 1'b0;
        end else begin
            if (in_start)                      k = 0;
            else if (m_beat >= 0 && m_beat < 3) k = m_beat + 1;
            else                               k = -1;
            x0 = (k >= 0) && (k % 2 == 1);
            x1 = (k >= 2);
            e_d0 = x0 ? in_data_1 : in_data_0;
            e_d1 = x0 ? in_data_0 : in_data_1;
            e_d2 = x1 ? in_data_3 : in_data_2;
            e_d3 = x1 ? in_data_2 : in_data_3;
            e_start = in_start;
            e_busy  = (k >= 0) && (k < 3);
            m_beat  = k;
        end
        m_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_data", {out_data_0, out_data_1, out_data_2, out_data_3},
                {e_d0, e_d1, e_d2, e_d3});
            chk("model_start", 32'(out_start), 32'(e_start));
            chk("model_busy", 32'(busy), 32'(e_busy));
        end
    end

    // Called at a negedge: apply inputs, return at the next negedge.
    task automatic drive(input logic s, input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        in_start  = s;
        rst       = r;
        in_data_0 = a;
        in_data_1 = b;
        in_data_2 = c;
        in_data_3 = d;
        @(negedge clk);
        $display("cyc t=%0t rst=%b start=%b in=%h_%h_%h_%h out=%h_%h_%h_%h ostart=%b busy=%b",
                 $time, r, s, a, b, c, d, out_data_0, out_data_1, out_data_2, out_data_3,
                 out_start, busy);
    endtask

    task automatic pin(input string name, input logic [31:0] dat, input logic st, input logic bz);
        chk({name, "_data"}, {out_data_0, out_data_1, out_data_2, out_data_3}, dat);
        chk({name, "_start"}, 32'(out_start), 32'(st));
        chk({name, "_busy"}, 32'(busy), 32'(bz));
    endtask

    initial begin
        rst = 1'b0; in_start = 1'b0;
        in_data_0 = 8'h55; in_data_1 = 8'h66; in_data_2 = 8'h77; in_data_3 = 8'h88;
        @(negedge clk);

        // Reset with live inputs, including a start request
        drive(1, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        drive(0, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        drive(0, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        pin("reset", 32'h0000_0000, 0, 0);
        drive(0, 1, 8'd1, 8'd2, 8'd3, 8'd4);
        pin("idle_pass", {8'd1, 8'd2, 8'd3, 8'd4}, 0, 0);

        // Single block
        drive(1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
        pin("blk_k0", {8'd10, 8'd20, 8'd30, 8'd40}, 1, 1);
        drive(0, 1, 8'd11, 8'd21, 8'd31, 8'd41);
        pin("blk_k1", {8'd21, 8'd11, 8'd31, 8'd41}, 0, 1);
        drive(0, 1, 8'd12, 8'd22, 8'd32, 8'd42);
        pin("blk_k2", {8'd12, 8'd22, 8'd42, 8'd32}, 0, 1);
        drive(0, 1, 8'd13, 8'd23, 8'd33, 8'd43);
        pin("blk_k3", {8'd23, 8'd13, 8'd43, 8'd33}, 0, 0);

        // Back-to-back: second start directly after beat 3
        drive(1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
        drive(0, 1, 8'd11, 8'd21, 8'd31, 8'd41);
        drive(0, 1, 8'd12, 8'd22, 8'd32, 8'd42);
        drive(0, 1, 8'd13, 8'd23, 8'd33, 8'd43);
        drive(1, 1, 8'd50, 8'd60, 8'd70, 8'd80);
        pin("b2b_k0", {8'd50, 8'd60, 8'd70, 8'd80}, 1, 1);
        drive(0, 1, 8'd51, 8'd61, 8'd71, 8'd81);
        pin("b2b_k1", {8'd61, 8'd51, 8'd71, 8'd81}, 0, 1);
        drive(0, 1, 8'd52, 8'd62, 8'd72, 8'd82);
        drive(0, 1, 8'd53, 8'd63, 8'd73, 8'd83);
        pin("b2b_k3", {8'd63, 8'd53, 8'd83, 8'd73}, 0, 0);

        // Restart at beat 2
        drive(1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
        drive(0, 1, 8'd11, 8'd21, 8'd31, 8'd41);
        drive(1, 1, 8'd12, 8'd22, 8'd32, 8'd42);
        pin("restart_k0", {8'd12, 8'd22, 8'd32, 8'd42}, 1, 1);
        drive(0, 1, 8'd13, 8'd23, 8'd33, 8'd43);
        pin("restart_k1", {8'd23, 8'd13, 8'd33, 8'd43}, 0, 1);
        drive(0, 1, 8'd14, 8'd24, 8'd34, 8'd44);
        drive(0, 1, 8'd15, 8'd25, 8'd35, 8'd45);
        drive(0, 1, 8'd16, 8'd26, 8'd36, 8'd46);
        pin("restart_idle", {8'd16, 8'd26, 8'd36, 8'd46}, 0, 0);

        // Reset at beat 2
        drive(1, 1, 8'd10, 8'd20, 8'd30, 8'd40);
        drive(0, 1, 8'd11, 8'd21, 8'd31, 8'd41);
        drive(0, 0, 8'd12, 8'd22, 8'd32, 8'd42);
        pin("midrst", 32'h0000_0000, 0, 0);
        drive(0, 1, 8'd13, 8'd23, 8'd33, 8'd43);
        pin("midrst_idle", {8'd13, 8'd23, 8'd33, 8'd43}, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(5) == 0), ($urandom_range(49) != 0),
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
